// File: rtl/alu_uart_if.sv
// Bundle of the UART-side and ALU-side signals seen by the frame controller.
// The slave modport is the controller's view; the master modport is its environment.
interface alu_uart_if #(
    parameter int DATA_BITS = 8,
    parameter int OP_BITS   = 6
);
    logic [DATA_BITS-1:0] i_rx_data;
    logic                 i_rx_done;
    logic [DATA_BITS-1:0] i_alu_result;
    logic                 i_tx_done;
    logic [DATA_BITS-1:0] o_alu_A;
    logic [DATA_BITS-1:0] o_alu_B;
    logic [OP_BITS-1:0]   o_alu_Op;
    logic [DATA_BITS-1:0] o_tx_data;
    logic                 o_tx_start;
    logic                 o_busy;

    modport slave (
        input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
        output o_alu_A, o_alu_B, o_alu_Op, o_tx_data, o_tx_start, o_busy
    );

    modport master (
        output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
        input  o_alu_A, o_alu_B, o_alu_Op, o_tx_data, o_tx_start, o_busy
    );
endinterface

// File: rtl/alu_uart_interface.sv
// Frames three RX bytes (A, B, opcode) into an ALU operation and sends the
// registered ALU result back as one TX byte, waiting for TX completion.
module alu_uart_interface #(
    parameter int DATA_BITS = 8,
    parameter int OP_BITS   = 6,
    parameter int TIMEOUT   = 1000
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    alu_uart_if.slave  bus
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT + 1) : 2;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [2:0] {
        S_A       = 3'd0,
        S_B       = 3'd1,
        S_OP      = 3'd2,
        S_EXEC    = 3'd3,
        S_SEND    = 3'd4,
        S_WAIT_TX = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] alu_a_q, alu_a_d;
    logic [DATA_BITS-1:0] alu_b_q, alu_b_d;
    logic [OP_BITS-1:0]   alu_op_q, alu_op_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;
    logic                 busy_q, busy_d;
    logic                 timeout_hit_s;

    // Expiry fires on the TIMEOUT-th consecutive idle cycle of a partial frame.
    assign timeout_hit_s = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // Next-state and next-output computation for the framing FSM
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        busy_d     = 1'b0;
        case (state_q)
            S_A: begin
                cnt_d = CNT_ZERO;
                if (bus.i_rx_done) begin
                    alu_a_d = bus.i_rx_data;
                    state_d = S_B;
                end else begin
                    state_d = S_A;
                end
            end
            S_B: begin
                if (bus.i_rx_done) begin
                    alu_b_d = bus.i_rx_data;
                    cnt_d   = CNT_ZERO;
                    state_d = S_OP;
                end else if (timeout_hit_s) begin
                    cnt_d   = CNT_ZERO;
                    state_d = S_A;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            S_OP: begin
                if (bus.i_rx_done) begin
                    alu_op_d = bus.i_rx_data[OP_BITS-1:0];
                    cnt_d    = CNT_ZERO;
                    state_d  = S_EXEC;
                end else if (timeout_hit_s) begin
                    cnt_d   = CNT_ZERO;
                    state_d = S_A;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            // The ALU registers the operands on this edge; its result is ready in S_SEND.
            S_EXEC: begin
                state_d = S_SEND;
            end
            S_SEND: begin
                tx_data_d  = bus.i_alu_result;
                tx_start_d = 1'b1;
                state_d    = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (bus.i_tx_done) begin
                    state_d = S_A;
                end else begin
                    state_d = S_WAIT_TX;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                state_d = S_A;
            end
        endcase
        if ((state_d == S_EXEC) || (state_d == S_SEND) || (state_d == S_WAIT_TX)) begin
            busy_d = 1'b1;
        end else begin
            busy_d = 1'b0;
        end
    end

    // State, timeout counter and registered outputs
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_A;
            cnt_q      <= CNT_ZERO;
            alu_a_q    <= {DATA_BITS{1'b0}};
            alu_b_q    <= {DATA_BITS{1'b0}};
            alu_op_q   <= {OP_BITS{1'b0}};
            tx_data_q  <= {DATA_BITS{1'b0}};
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.o_alu_A    = alu_a_q;
    assign bus.o_alu_B    = alu_b_q;
    assign bus.o_alu_Op   = alu_op_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_tx_start = tx_start_q;
    assign bus.o_busy     = busy_q;
endmodule

// File: tb/tb_alu_uart_interface.sv
// Bench for alu_uart_interface: registered ALU stub, queue-based frame model,
// table-driven frames, hand-written corner sequences and randomized traffic.
module tb_alu_uart_interface;
    localparam int TMO = 16;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    alu_uart_if #(.DATA_BITS(8), .OP_BITS(6)) bus ();

    alu_uart_interface #(.DATA_BITS(8), .OP_BITS(6), .TIMEOUT(TMO)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        logic signed [7:0] sa;
        sa = a;
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h02:   return a >> b[2:0];
            6'h03:   return sa >>> b[2:0];
            default: return 8'h00;
        endcase
    endfunction

    // Registered ALU stand-in driven by the DUT operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.i_alu_result <= 8'h00;
        else        bus.i_alu_result <= alu_ref(bus.o_alu_A, bus.o_alu_B, bus.o_alu_Op);
    end

    // Frame model: bytes of the current frame, idle count, pending transmission
    logic [7:0] m_frame[$];
    int         m_idle, cyc, m_launch;
    logic       m_waiting, m_start;
    logic [7:0] m_A, m_B, m_tx, m_result;
    logic [5:0] m_Op;

    task automatic model_clear();
        m_frame.delete();
        m_idle = 0; m_waiting = 1'b0; m_start = 1'b0; m_launch = 0;
        m_A = 8'h00; m_B = 8'h00; m_Op = 6'h00; m_tx = 8'h00; m_result = 8'h00;
    endtask

    task automatic model_edge(input logic rxd, input logic [7:0] rxb, input logic txd);
        cyc++;
        m_start = 1'b0;
        if (m_waiting) begin
            if (cyc == m_launch) begin
                m_start = 1'b1;
                m_tx    = m_result;
            end else if (cyc > m_launch && txd) begin
                m_waiting = 1'b0;
            end
        end else if (rxd) begin
            m_frame.push_back(rxb);
            m_idle = 0;
            if (m_frame.size() == 1) m_A = rxb;
            else if (m_frame.size() == 2) m_B = rxb;
            else begin
                m_Op      = rxb[5:0];
                m_result  = alu_ref(m_frame[0], m_frame[1], rxb[5:0]);
                m_waiting = 1'b1;
                m_launch  = cyc + 2;
                m_frame.delete();
            end
        end else if (m_frame.size() > 0) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_frame.delete();
                m_idle = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_all();
        chk("alu_A",    32'(bus.o_alu_A),    32'(m_A));
        chk("alu_B",    32'(bus.o_alu_B),    32'(m_B));
        chk("alu_Op",   32'(bus.o_alu_Op),   32'(m_Op));
        chk("tx_data",  32'(bus.o_tx_data),  32'(m_tx));
        chk("tx_start", 32'(bus.o_tx_start), 32'(m_start));
        chk("busy",     32'(bus.o_busy),     32'(m_waiting));
    endtask

    // Called at a negedge; applies inputs for one rising edge and checks after it.
    task automatic step(input logic rxd, input logic [7:0] rxb, input logic txd);
        bus.i_rx_done = rxd;
        bus.i_rx_data = rxb;
        bus.i_tx_done = txd;
        @(posedge clk);
        model_edge(rxd, rxb, txd);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        bus.i_rx_done = 1'b0; bus.i_rx_data = 8'h00; bus.i_tx_done = 1'b0;
        rst_n = 1'b0;
        model_clear();
        #1;
        check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        chk("reset_busy", 32'(bus.o_busy), 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input logic [7:0] exp);
        step(1'b1, a, 1'b0);
        idle(1);
        step(1'b1, b, 1'b0);
        step(1'b1, op, 1'b0);
        chk("busy_after_op", 32'(bus.o_busy), 32'd1);
        idle(1);
        chk("start_early", 32'(bus.o_tx_start), 32'd0);
        idle(1);
        chk("start_lat2", 32'(bus.o_tx_start), 32'd1);
        chk("tx_result", 32'(bus.o_tx_data), 32'(exp));
        idle(2);
        chk("start_pulse", 32'(bus.o_tx_start), 32'd0);
        chk("busy_wait", 32'(bus.o_busy), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        chk("busy_done", 32'(bus.o_busy), 32'd0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] ops_ok[8];

    initial begin
        rst_n = 1'b0;
        bus.i_rx_done = 1'b0; bus.i_rx_data = 8'h00; bus.i_tx_done = 1'b0;
        cyc = 0;
        model_clear();
        vecs = '{
            '{8'h05, 8'h03, 8'h20, 8'h08}, '{8'h03, 8'h05, 8'h22, 8'hFE},
            '{8'h0F, 8'hF0, 8'h25, 8'hFF}, '{8'h0C, 8'h0A, 8'h24, 8'h08},
            '{8'hFF, 8'h01, 8'h20, 8'h00}, '{8'hAA, 8'h55, 8'h26, 8'hFF},
            '{8'hF0, 8'h0F, 8'h27, 8'h00}, '{8'h80, 8'h02, 8'h03, 8'hE0},
            '{8'h80, 8'h02, 8'h02, 8'h20}, '{8'h12, 8'h34, 8'h3F, 8'h00},
            '{8'h05, 8'h03, 8'hE0, 8'h08}, '{8'h00, 8'h01, 8'h22, 8'hFF}
        };
        ops_ok = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03};

        @(negedge clk);
        do_reset();
        idle(2);

        foreach (vecs[i]) send_frame(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);

        // Timeout after A: 16 idle cycles discard 0xAA
        step(1'b1, 8'hAA, 1'b0);
        idle(TMO);
        send_frame(8'h0F, 8'hF0, 8'h25, 8'hFF);
        chk("timeout_A", 32'(bus.o_alu_A), 32'h0F);

        // Byte on the expiry cycle is accepted
        step(1'b1, 8'h07, 1'b0);
        idle(TMO - 1);
        step(1'b1, 8'h02, 1'b0);
        step(1'b1, 8'h20, 1'b0);
        idle(2);
        chk("expiry_win", 32'(bus.o_tx_data), 32'h09);
        step(1'b0, 8'h00, 1'b1);

        // Timeout while waiting for the opcode
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        idle(TMO);
        send_frame(8'h03, 8'h04, 8'h20, 8'h07);

        // rx_done while waiting for TX, and coincident with tx_done, both dropped
        step(1'b1, 8'h05, 1'b0);
        step(1'b1, 8'h03, 1'b0);
        step(1'b1, 8'h20, 1'b0);
        idle(3);
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h33, 1'b1);
        chk("ignore_busy", 32'(bus.o_busy), 32'd0);
        chk("ignore_A", 32'(bus.o_alu_A), 32'h05);
        send_frame(8'h0C, 8'h0A, 8'h24, 8'h08);

        // Reset while waiting for TX completion
        step(1'b1, 8'h09, 1'b0);
        step(1'b1, 8'h09, 1'b0);
        step(1'b1, 8'h20, 1'b0);
        idle(3);
        do_reset();
        idle(5);
        chk("no_restart", 32'(bus.o_tx_start), 32'd0);
        send_frame(8'h01, 8'h01, 8'h20, 8'h02);

        // Randomized traffic with varying byte density
        for (int burst = 0; burst < 40; burst++) begin
            int p;
            p = int'($urandom_range(1, 20));
            for (int s = 0; s < 60; s++) begin
                logic       rxd, txd;
                logic [7:0] rxb;
                rxd = ($urandom_range(0, p - 1) == 0);
                txd = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 1) == 0) rxb = ops_ok[$urandom_range(0, 7)];
                else                           rxb = 8'($urandom);
                step(rxd, rxb, txd);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
